round_ctrl: RTL and testbench

Game-round sequencer for the binary number game, sitting on the initiator side of the seconds timer. It loads the timer and draws an 8-bit target from an LFSR. It then waits for the player's switch guess or the timer's expiry flag, scores the round, and advances through a fixed number of rounds to game over. It drives the timer's load flag and load value, and consumes the timer's remaining-seconds count and expiry flag.

---
 rtl/game_pkg.sv | 24 ++
 rtl/lfsr8.sv | 27 ++
 rtl/round_ctrl.sv | 127 ++++++++++++
 tb/tb_round_ctrl.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and constants for the binary number game: round FSM states,
// datapath widths and the target LFSR step function.
package game_pkg;

    localparam int TIME_W = 5;
    localparam int NUM_W  = 8;
    localparam int CNT_W  = 4;

    // Taps for x^8+x^6+x^5+x^4+1 on a left-shifting register (bits 7,5,4,3)
    localparam logic [NUM_W-1:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_PLAY = 3'd2,
        ST_NEXT = 3'd3,
        ST_OVER = 3'd4
    } state_t;

    function automatic logic [NUM_W-1:0] lfsr_step(input logic [NUM_W-1:0] v);
        return {v[NUM_W-2:0], ^(v & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; a nonzero seed keeps it off the all-zero
// lock-up state, so every value it presents is nonzero.
module lfsr8
    import game_pkg::*;
#(
    parameter logic [NUM_W-1:0] SEED = 8'hA5
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [NUM_W-1:0] value_o
);

    logic [NUM_W-1:0] lfsr_q;
    logic [NUM_W-1:0] lfsr_d;

    assign lfsr_d  = lfsr_step(lfsr_q);
    assign value_o = lfsr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

endmodule

// File: rtl/round_ctrl.sv
// Round sequencer for the binary number game: loads the seconds timer, draws a
// target, scores the player's guess or the timer expiry, and counts rounds.
module round_ctrl
    import game_pkg::*;
#(
    parameter logic [TIME_W-1:0] ROUND_TIME = 5'd20,
    parameter logic [CNT_W-1:0]  NUM_ROUNDS = 4'd10,
    parameter logic [NUM_W-1:0]  LFSR_SEED  = 8'hA5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              submit,
    input  logic [NUM_W-1:0]  guess,
    input  logic [TIME_W-1:0] timeleft,
    input  logic              end_f,
    output logic              time_f,
    output logic [TIME_W-1:0] time_v,
    output logic [NUM_W-1:0]  target,
    output logic [CNT_W-1:0]  score,
    output logic [CNT_W-1:0]  round,
    output logic              last_correct,
    output logic              timed_out,
    output logic              playing,
    output logic              game_over,
    output logic [TIME_W-1:0] secs
);

    state_t            state_q, state_d;
    logic [NUM_W-1:0]  target_q, target_d;
    logic [CNT_W-1:0]  score_q, score_d;
    logic [CNT_W-1:0]  round_q, round_d;
    logic              last_correct_q, last_correct_d;
    logic              timed_out_q, timed_out_d;
    logic              time_f_q, playing_q, game_over_q;
    logic [TIME_W-1:0] secs_q;
    logic [NUM_W-1:0]  lfsr_val;

    lfsr8 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .value_o (lfsr_val)
    );

    always_comb begin
        state_d        = state_q;
        target_d       = target_q;
        score_d        = score_q;
        round_d        = round_q;
        last_correct_d = last_correct_q;
        timed_out_d    = timed_out_q;
        case (state_q)
            ST_IDLE, ST_OVER: begin
                if (start) begin
                    state_d = ST_LOAD;
                    score_d = '0;
                    round_d = '0;
                end
            end
            ST_LOAD: begin
                target_d = lfsr_val;
                state_d  = ST_PLAY;
            end
            ST_PLAY: begin
                // Expiry takes priority: a guess landing on the same cycle is discarded
                if (end_f) begin
                    last_correct_d = 1'b0;
                    timed_out_d    = 1'b1;
                    state_d        = ST_NEXT;
                end else if (submit) begin
                    timed_out_d    = 1'b0;
                    last_correct_d = (guess == target_q);
                    if (guess == target_q) begin
                        score_d = score_q + CNT_W'(1);
                    end
                    state_d = ST_NEXT;
                end
            end
            ST_NEXT: begin
                round_d = round_q + CNT_W'(1);
                state_d = (round_d == NUM_ROUNDS) ? ST_OVER : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            target_q       <= '0;
            score_q        <= '0;
            round_q        <= '0;
            last_correct_q <= 1'b0;
            timed_out_q    <= 1'b0;
            time_f_q       <= 1'b0;
            playing_q      <= 1'b0;
            game_over_q    <= 1'b0;
            secs_q         <= '0;
        end else begin
            state_q        <= state_d;
            target_q       <= target_d;
            score_q        <= score_d;
            round_q        <= round_d;
            last_correct_q <= last_correct_d;
            timed_out_q    <= timed_out_d;
            // Status flags are decoded from the next state so they line up with it
            time_f_q       <= (state_d == ST_LOAD);
            playing_q      <= (state_d == ST_PLAY);
            game_over_q    <= (state_d == ST_OVER);
            secs_q         <= timeleft;
        end
    end

    assign time_f       = time_f_q;
    assign time_v       = ROUND_TIME;
    assign target       = target_q;
    assign score        = score_q;
    assign round        = round_q;
    assign last_correct = last_correct_q;
    assign timed_out    = timed_out_q;
    assign playing      = playing_q;
    assign game_over    = game_over_q;
    assign secs         = secs_q;

endmodule

// File: tb/tb_round_ctrl.sv
// Bench for round_ctrl: a game-level reference model checked every cycle,
// plus directed rounds with literal expectations that pin the model.
module tb_round_ctrl;

    localparam int N_ROUNDS = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       submit = 1'b0;
    logic       end_f = 1'b0;
    logic [7:0] guess = 8'h00;
    logic [4:0] timeleft = 5'd31;

    logic       time_f;
    logic [4:0] time_v;
    logic [7:0] target;
    logic [3:0] score;
    logic [3:0] round;
    logic       last_correct;
    logic       timed_out;
    logic       playing;
    logic       game_over;
    logic [4:0] secs;

    int checks = 0;
    int failures = 0;
    bit check_en = 1'b0;

    round_ctrl #(
        .ROUND_TIME (5'd20),
        .NUM_ROUNDS (4'd3),
        .LFSR_SEED  (8'hA5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .submit       (submit),
        .guess        (guess),
        .timeleft     (timeleft),
        .end_f        (end_f),
        .time_f       (time_f),
        .time_v       (time_v),
        .target       (target),
        .score        (score),
        .round        (round),
        .last_correct (last_correct),
        .timed_out    (timed_out),
        .playing      (playing),
        .game_over    (game_over),
        .secs         (secs)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(negedge clk);
            timeleft = timeleft - 5'd1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Game-level model: a phase of the game plus its score sheet
    localparam int P_IDLE = 0, P_LOAD = 1, P_PLAY = 2, P_NEXT = 3, P_OVER = 4;
    int         m_phase = P_IDLE;
    int         m_score = 0;
    int         m_round = 0;
    bit         m_lc = 1'b0;
    bit         m_to = 1'b0;
    logic [7:0] m_lfsr = 8'hA5;
    logic [7:0] m_target = 8'h00;
    logic [4:0] m_secs = 5'd0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase  <= P_IDLE;
            m_score  <= 0;
            m_round  <= 0;
            m_lc     <= 1'b0;
            m_to     <= 1'b0;
            m_lfsr   <= 8'hA5;
            m_target <= 8'h00;
            m_secs   <= 5'd0;
        end else begin
            m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
            m_secs <= timeleft;
            if (m_phase == P_IDLE || m_phase == P_OVER) begin
                if (start) begin
                    m_phase <= P_LOAD;
                    m_score <= 0;
                    m_round <= 0;
                end
            end else if (m_phase == P_LOAD) begin
                m_target <= m_lfsr;
                m_phase  <= P_PLAY;
            end else if (m_phase == P_PLAY) begin
                if (end_f) begin
                    m_lc    <= 1'b0;
                    m_to    <= 1'b1;
                    m_phase <= P_NEXT;
                end else if (submit) begin
                    m_to    <= 1'b0;
                    m_lc    <= (guess == m_target);
                    m_score <= m_score + ((guess == m_target) ? 1 : 0);
                    m_phase <= P_NEXT;
                end
            end else begin
                m_round <= m_round + 1;
                m_phase <= (m_round + 1 >= N_ROUNDS) ? P_OVER : P_LOAD;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            chk("time_f", time_f, (m_phase == P_LOAD) ? 1 : 0);
            chk("time_v", time_v, 20);
            chk("target", target, m_target);
            chk("score", score, m_score);
            chk("round", round, m_round);
            chk("last_correct", last_correct, m_lc);
            chk("timed_out", timed_out, m_to);
            chk("playing", playing, (m_phase == P_PLAY) ? 1 : 0);
            chk("game_over", game_over, (m_phase == P_OVER) ? 1 : 0);
            chk("secs", secs, m_secs);
            chk("lfsr", dut.lfsr_val, m_lfsr);
            chk("lfsr_nonzero", (dut.lfsr_val != 8'h00) ? 1 : 0, 1);
        end
    end

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // kind: 0 correct guess, 1 wrong guess, 2 expiry, 3 correct guess with expiry
    task automatic play_round(input int kind);
        int n;
        n = 0;
        while (!playing && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("play_wait", playing, 1);
        guess  = (kind == 1) ? (m_target ^ 8'h01) : m_target;
        submit = (kind != 2);
        end_f  = (kind >= 2);
        @(negedge clk);
        submit = 1'b0;
        end_f  = 1'b0;
        $display("round kind=%0d target=%02h guess=%02h score=%0d last_correct=%0b timed_out=%0b",
                 kind, m_target, guess, score, last_correct, timed_out);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        check_en = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_target", target, 0);
        chk("rst_time_v", time_v, 20);
        rst_n = 1'b1;
        #1 chk("lfsr_seed", dut.lfsr_val, 8'hA5);
        @(negedge clk);
        chk("lfsr_step1", dut.lfsr_val, 8'h4A);
        @(negedge clk);
        chk("lfsr_step2", dut.lfsr_val, 8'h95);

        // Stale expiry in IDLE must do nothing
        end_f = 1'b1;
        @(negedge clk);
        end_f = 1'b0;
        @(negedge clk);
        chk("idle_endf_to", timed_out, 0);
        chk("idle_endf_play", playing, 0);

        // Game 1: correct, wrong, expiry
        pulse_start();
        chk("g1_time_f", time_f, 1);
        chk("g1_time_v", time_v, 20);
        @(negedge clk);
        chk("g1_playing", playing, 1);
        chk("g1_time_f_off", time_f, 0);
        chk("g1_target_nz", (target != 8'h00) ? 1 : 0, 1);
        play_round(0);
        chk("g1r1_score", score, 1);
        chk("g1r1_lc", last_correct, 1);
        end_f = 1'b1;
        @(negedge clk);
        end_f = 1'b0;
        chk("g1r1_round", round, 1);
        chk("g1r1_time_f2", time_f, 1);
        chk("g1r1_next_endf", timed_out, 0);
        play_round(1);
        chk("g1r2_score", score, 1);
        chk("g1r2_lc", last_correct, 0);
        chk("g1r2_to", timed_out, 0);
        play_round(2);
        chk("g1r3_to", timed_out, 1);
        chk("g1r3_lc", last_correct, 0);
        @(negedge clk);
        chk("g1_over", game_over, 1);
        chk("g1_over_round", round, 3);
        chk("g1_over_score", score, 1);
        guess  = m_target;
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        @(negedge clk);
        chk("g1_over_submit", score, 1);

        // Game 2: simultaneous submit and expiry, then two correct rounds
        pulse_start();
        chk("g2_time_f", time_f, 1);
        play_round(3);
        chk("g2r1_score", score, 0);
        chk("g2r1_to", timed_out, 1);
        chk("g2r1_lc", last_correct, 0);
        play_round(0);
        play_round(0);
        @(negedge clk);
        chk("g2_over_score", score, 2);
        chk("g2_over", game_over, 1);

        // Game 3: three correct rounds, then restart from OVER
        pulse_start();
        play_round(0);
        play_round(0);
        play_round(0);
        @(negedge clk);
        chk("g3_over", game_over, 1);
        chk("g3_score", score, 3);
        chk("g3_round", round, 3);
        guess  = m_target;
        submit = 1'b1;
        @(negedge clk);
        submit = 1'b0;
        chk("g3_over_submit", score, 3);
        pulse_start();
        chk("g4_time_f", time_f, 1);
        chk("g4_score_clr", score, 0);
        chk("g4_round_clr", round, 0);
        chk("g4_over_clr", game_over, 0);

        // Game 4: asynchronous reset in the middle of round 3
        play_round(0);
        play_round(0);
        @(negedge clk);
        @(negedge clk);
        chk("g4_playing", playing, 1);
        chk("g4_score", score, 2);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_time_f", time_f, 0);
        chk("ar_time_v", time_v, 20);
        chk("ar_target", target, 0);
        chk("ar_score", score, 0);
        chk("ar_round", round, 0);
        chk("ar_lc", last_correct, 0);
        chk("ar_to", timed_out, 0);
        chk("ar_playing", playing, 0);
        chk("ar_over", game_over, 0);
        chk("ar_secs", secs, 0);
        chk("ar_lfsr", dut.lfsr_val, 8'hA5);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("ar_lfsr_seed", dut.lfsr_val, 8'hA5);
        repeat (255) @(negedge clk);
        chk("lfsr_period", dut.lfsr_val, 8'hA5);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
